// File: rtl/mixer_cplx_pkg.sv
// -----------------------------------------------------------------------------
// mixer_cplx_pkg
// Shared types for the time-multiplexed complex mixer.
//   mixer_mode_e  : per-sample input format (real or complex).
//   mixer_state_e : sequencer states, also exported on the debug state port.
// Round/saturate widths differ per instance, so that logic lives in the
// parameterised mixer_round_sat module rather than in a package function.
// -----------------------------------------------------------------------------
package mixer_cplx_pkg;

  typedef enum logic {
    MIX_REAL    = 1'b0,
    MIX_COMPLEX = 1'b1
  } mixer_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL_II = 3'd1,
    ST_MUL_QQ = 3'd2,
    ST_MUL_IQ = 3'd3,
    ST_MUL_QI = 3'd4,
    ST_OUT    = 3'd5
  } mixer_state_e;

endpackage

// File: rtl/mixer_cplx_round_sat.sv
// -----------------------------------------------------------------------------
// mixer_round_sat
// Combinational round-half-up and saturate of one accumulator component.
//   acc_i : signed accumulator, ACC_W bits
//   out_o : signed result, OUT_W bits, (acc + 2^(SHIFT-1)) >>> SHIFT clipped
//           to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   ovf_o : high when clipping happened
// -----------------------------------------------------------------------------
module mixer_round_sat #(
  parameter int ACC_W = 37,
  parameter int SHIFT = 17,
  parameter int OUT_W = 18
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] out_o,
  output logic                    ovf_o
);

  localparam int SH_W = ACC_W + 1 - SHIFT;
  localparam logic [ACC_W:0] RND = {{(ACC_W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

  // One guard bit so adding the half-LSB can never wrap.
  logic signed [ACC_W:0] sum;
  logic        [SH_W-1:0] sh;

  assign sum = $signed({acc_i[ACC_W-1], acc_i} + RND);
  assign sh  = SH_W'(sum >>> SHIFT);

  generate
    if (SH_W > OUT_W) begin : g_sat
      // The value fits iff every bit above the output sign bit copies it.
      logic [SH_W-OUT_W:0] top;
      logic                clip;

      assign top  = sh[SH_W-1:OUT_W-1];
      assign clip = !((top == '0) || (top == '1));
      assign ovf_o = clip;

      always_comb begin
        out_o = sh[OUT_W-1:0];
        if (clip) begin
          out_o = sh[SH_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end else begin : g_ext
      assign ovf_o = 1'b0;
      assign out_o = OUT_W'($signed(sh));
    end
  endgenerate

endmodule

// File: rtl/mixer_cplx.sv
// -----------------------------------------------------------------------------
// mixer_cplx
// Time-multiplexed complex mixer: multiplies each accepted sample by the NCO
// phasor (optionally conjugated) using one shared multiplier, then rounds
// half-up and saturates to OUT_W bits.
//
// Ports
//   ipClk, ipReset   : clock, asynchronous active-high reset
//   ipInI, ipInQ     : input sample (Q ignored in real mode)
//   ipNcoI, ipNcoQ   : NCO cos/sin, Q(NCO_W-1)
//   ipMode           : 0 real input, 1 complex input
//   ipConj           : 1 multiplies by conj(NCO)
//   ipValid/opReady  : input handshake
//   opI, opQ         : rounded/saturated result
//   opOverflow       : either component of the current result clipped
//   opValid/ipReady  : output handshake
//   opDbgState       : sequencer state, for observation only
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The sender holds data stable while valid && !ready; ready
// may depend combinationally on the other side's ready, never on valid.
//
// With s = -1 when conjugating, else +1:
//   complex: I = xI*cI - s*xQ*cQ,  Q = s*xI*cQ + xQ*cI
//   real   : I = xI*cI,            Q = s*xI*cQ
// -----------------------------------------------------------------------------
module mixer_cplx
  import mixer_cplx_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int NCO_W = 18,
  parameter int OUT_W = 18
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  logic signed [IN_W-1:0]  ipInI,
  input  logic signed [IN_W-1:0]  ipInQ,
  input  logic signed [NCO_W-1:0] ipNcoI,
  input  logic signed [NCO_W-1:0] ipNcoQ,
  input  logic                    ipMode,
  input  logic                    ipConj,
  input  logic                    ipValid,
  output logic                    opReady,
  output logic signed [OUT_W-1:0] opI,
  output logic signed [OUT_W-1:0] opQ,
  output logic                    opOverflow,
  output logic                    opValid,
  input  logic                    ipReady,
  output mixer_state_e            opDbgState
);

  localparam int PROD_W = IN_W + NCO_W;
  localparam int ACC_W  = PROD_W + 1;

  mixer_state_e            state_q;
  mixer_mode_e             mode_q;
  logic                    conj_q;
  logic signed [IN_W-1:0]  x_i_q, x_q_q;
  logic signed [NCO_W-1:0] c_i_q, c_q_q;
  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [OUT_W-1:0] out_i_q, out_q_q;
  logic                    ovf_q;
  logic                    valid_q;

  logic signed [IN_W-1:0]  mul_a;
  logic signed [NCO_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;

  logic signed [OUT_W-1:0] rs_i, rs_q;
  logic                    rs_ovf_i, rs_ovf_q;

  logic out_busy;
  logic consume;
  logic accept;

  // Output register holds a result the downstream has not taken yet.
  assign out_busy = valid_q && !ipReady;
  assign consume  = valid_q && ipReady;
  assign opReady  = (state_q == ST_IDLE) && !out_busy && !ipReset;
  assign accept   = ipValid && opReady;

  // Shared multiplier operand select, one product per MUL state.
  always_comb begin
    mul_a = x_i_q;
    mul_b = c_i_q;
    unique case (state_q)
      ST_MUL_QQ: begin mul_a = x_q_q; mul_b = c_q_q; end
      ST_MUL_IQ: begin mul_a = x_i_q; mul_b = c_q_q; end
      ST_MUL_QI: begin mul_a = x_q_q; mul_b = c_i_q; end
      default:   ;
    endcase
  end

  assign prod     = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign prod_ext = {prod[PROD_W-1], prod};

  mixer_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (NCO_W - 1),
    .OUT_W (OUT_W)
  ) u_rs_i (
    .acc_i (acc_i_q),
    .out_o (rs_i),
    .ovf_o (rs_ovf_i)
  );

  mixer_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (NCO_W - 1),
    .OUT_W (OUT_W)
  ) u_rs_q (
    .acc_i (acc_q_q),
    .out_o (rs_q),
    .ovf_o (rs_ovf_q)
  );

  // Sequencer. Each MUL state folds its product straight into the
  // accumulator on the same edge, so real mode takes II, IQ, OUT and complex
  // mode takes II, QQ, IQ, QI, OUT before opValid rises.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q <= ST_IDLE;
      mode_q  <= MIX_REAL;
      conj_q  <= 1'b0;
      x_i_q   <= '0;
      x_q_q   <= '0;
      c_i_q   <= '0;
      c_q_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // A result landing in ST_OUT below overrides this clear.
      if (consume) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_i_q   <= ipInI;
            x_q_q   <= ipInQ;
            c_i_q   <= ipNcoI;
            c_q_q   <= ipNcoQ;
            mode_q  <= ipMode ? MIX_COMPLEX : MIX_REAL;
            conj_q  <= ipConj;
            state_q <= ST_MUL_II;
          end
        end
        ST_MUL_II: begin
          acc_i_q <= prod_ext;
          state_q <= (mode_q == MIX_COMPLEX) ? ST_MUL_QQ : ST_MUL_IQ;
        end
        ST_MUL_QQ: begin
          // -s*xQ*cQ: subtract normally, add when conjugating.
          acc_i_q <= conj_q ? (acc_i_q + prod_ext) : (acc_i_q - prod_ext);
          state_q <= ST_MUL_IQ;
        end
        ST_MUL_IQ: begin
          acc_q_q <= conj_q ? -prod_ext : prod_ext;
          state_q <= (mode_q == MIX_COMPLEX) ? ST_MUL_QI : ST_OUT;
        end
        ST_MUL_QI: begin
          acc_q_q <= acc_q_q + prod_ext;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          // Stall until the previous result is gone or leaves this edge.
          if (!out_busy) begin
            out_i_q <= rs_i;
            out_q_q <= rs_q;
            ovf_q   <= rs_ovf_i | rs_ovf_q;
            valid_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign opI        = out_i_q;
  assign opQ        = out_q_q;
  assign opOverflow = ovf_q;
  assign opValid    = valid_q;
  assign opDbgState = state_q;

endmodule

// File: tb/tb_mixer_cplx.sv
module tb_mixer_cplx;
  import mixer_cplx_pkg::*;

  localparam int IN_W  = 18;
  localparam int NCO_W = 18;
  localparam int OUT_W = 18;
  localparam int RW    = 2 * OUT_W + 1;
  localparam int NV    = 9;
  localparam int NS    = 8;

  typedef struct packed {
    logic                    ovf;
    logic signed [OUT_W-1:0] q;
    logic signed [OUT_W-1:0] i;
  } res_t;

  typedef struct {
    logic signed [IN_W-1:0]  xi, xq;
    logic signed [NCO_W-1:0] ci, cq;
    logic                    mode, conj;
    logic signed [OUT_W-1:0] ei, eq;
    logic                    eovf;
    int                      lat;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [IN_W-1:0]  ipInI, ipInQ;
  logic signed [NCO_W-1:0] ipNcoI, ipNcoQ;
  logic                    ipMode, ipConj, ipValid, ipReady;
  logic                    opReady, opOverflow, opValid;
  logic signed [OUT_W-1:0] opI, opQ;
  mixer_state_e            opDbgState;

  mixer_cplx #(.IN_W(IN_W), .NCO_W(NCO_W), .OUT_W(OUT_W)) dut (
    .ipClk      (clk),
    .ipReset    (rst),
    .ipInI      (ipInI),
    .ipInQ      (ipInQ),
    .ipNcoI     (ipNcoI),
    .ipNcoQ     (ipNcoQ),
    .ipMode     (ipMode),
    .ipConj     (ipConj),
    .ipValid    (ipValid),
    .opReady    (opReady),
    .opI        (opI),
    .opQ        (opQ),
    .opOverflow (opOverflow),
    .opValid    (opValid),
    .ipReady    (ipReady),
    .opDbgState (opDbgState)
  );

  // ---------------- scoreboard ----------------
  int n_applied = 0;
  int n_miscomp = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_applied++;
    if (act != exp) begin
      n_miscomp++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every consumed output is compared, in order, against the expected queue.
  always @(negedge clk) begin
    if (!rst && opValid && ipReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        res_t r;
        r = res_t'(exp_q.pop_front());
        check("out_i", opI, longint'($signed(r.i)));
        check("out_q", opQ, longint'($signed(r.q)));
        check("out_ovf", opOverflow, r.ovf);
      end
    end
  end

  // ---------------- vectors and model ----------------
  function automatic vec_t mk(input int xi, input int xq, input int ci, input int cq,
                              input bit mode, input bit conj,
                              input int ei, input int eq, input bit eovf, input int lat);
    vec_t v;
    v.xi = xi[IN_W-1:0];
    v.xq = xq[IN_W-1:0];
    v.ci = ci[NCO_W-1:0];
    v.cq = cq[NCO_W-1:0];
    v.mode = mode;
    v.conj = conj;
    v.ei = ei[OUT_W-1:0];
    v.eq = eq[OUT_W-1:0];
    v.eovf = eovf;
    v.lat = lat;
    return v;
  endfunction

  function automatic logic [RW-1:0] pack_exp(input vec_t v);
    res_t r;
    r.ovf = v.eovf;
    r.q   = v.eq;
    r.i   = v.ei;
    return r;
  endfunction

  function automatic longint rsat(input longint v, output logic o);
    longint r, hi, lo;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    r  = (v + (longint'(1) <<< (NCO_W - 2))) >>> (NCO_W - 1);
    o  = 1'b0;
    if (r > hi) begin r = hi; o = 1'b1; end
    if (r < lo) begin r = lo; o = 1'b1; end
    return r;
  endfunction

  // Plain complex arithmetic on 64-bit integers.
  function automatic logic [RW-1:0] model(input vec_t v);
    longint xi, xq, ci, cq, s, vi, vq, ri, rq;
    logic oi, oq;
    res_t r;
    xi = v.xi; xq = v.xq; ci = v.ci; cq = v.cq;
    s  = v.conj ? -1 : 1;
    if (v.mode) begin
      vi = xi * ci - s * xq * cq;
      vq = s * xi * cq + xq * ci;
    end else begin
      vi = xi * ci;
      vq = s * xi * cq;
    end
    ri = rsat(vi, oi);
    rq = rsat(vq, oq);
    r.i = ri[OUT_W-1:0];
    r.q = rq[OUT_W-1:0];
    r.ovf = oi | oq;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    ipInI   = v.xi;
    ipInQ   = v.xq;
    ipNcoI  = v.ci;
    ipNcoQ  = v.cq;
    ipMode  = v.mode;
    ipConj  = v.conj;
    ipValid = 1'b1;
  endtask

  // Returns just after the accept edge; t is the cycle count just before it.
  task automatic wait_accept(input string name, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!opReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_accept"}, opReady, 1);
    t = cyc;
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accept edge to the edge that raises opValid.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!opValid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscomp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
    n_miscomp++;
    summary();
    $finish;
  end

  // ---------------- test ----------------
  vec_t vecs[NV];
  vec_t sv[NS];
  int   t_acc[NS];

  initial begin
    int t, lat, n;

    // Q17 scaling: 16384*16384 = 2^28 -> 2^28 / 2^17 = 2048.
    vecs[0] = mk(16384, 0, 16384, -16384, 0, 0, 2048, -2048, 0, 3);
    vecs[1] = mk(16384, 8192, 16384, 16384, 1, 0, 1024, 3072, 0, 5);
    vecs[2] = mk(16384, 8192, 16384, 16384, 1, 1, 3072, -1024, 0, 5);
    vecs[3] = mk(-131072, 0, -131072, 0, 0, 0, 131071, 0, 1, 3);
    vecs[4] = mk(1, 0, 65536, 0, 0, 0, 1, 0, 0, 3);
    vecs[5] = mk(-1, 0, 65536, 0, 0, 0, 0, 0, 0, 3);
    vecs[6] = mk(-131072, -131072, -131072, -131072, 1, 0, 0, 131071, 1, 5);
    vecs[7] = mk(16384, 999, 16384, -16384, 0, 1, 2048, 2048, 0, 3);
    vecs[8] = mk(-131072, 131071, 131071, 131071, 1, 0, -131072, -1, 1, 5);

    for (int k = 0; k < NS; k++) begin
      sv[k] = mk(-120000 + 31000 * k, 90000 - 23000 * k, 70000 - 19000 * k, -50000 + 20000 * k,
                 (k % 2) == 1, ((k / 2) % 2) == 1, 0, 0, 0, 0);
    end
    sv[5] = mk(-131072, -131072, -131072, -131072, 1, 0, 0, 0, 0, 0);

    // Reset state, with a valid sample offered that must not be taken.
    rst = 1'b1;
    ipInI = 18'sd100; ipInQ = 18'sd100; ipNcoI = 18'sd100; ipNcoQ = 18'sd100;
    ipMode = 1'b0; ipConj = 1'b0; ipValid = 1'b1; ipReady = 1'b1;
    #12;
    check("rst_valid", opValid, 0);
    check("rst_i", opI, 0);
    check("rst_q", opQ, 0);
    check("rst_ovf", opOverflow, 0);
    check("rst_ready", opReady, 0);
    check("rst_state", int'(opDbgState), int'(ST_IDLE));
    ipValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    for (int k = 0; k < NV; k++) begin
      exp_q.push_back(pack_exp(vecs[k]));
      drive(vecs[k]);
      wait_accept($sformatf("v%0d", k), t);
      ipValid = 1'b0;
      wait_valid(lat);
      check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
      @(posedge clk);
      #1;
    end

    // Backpressure: result held while ipReady is low; a held sample waits.
    ipReady = 1'b0;
    exp_q.push_back(pack_exp(vecs[0]));
    drive(vecs[0]);
    wait_accept("bp_a", t);
    ipValid = 1'b0;
    wait_valid(lat);
    check("bp_a_latency", lat, 3);
    @(posedge clk);
    #1;
    drive(vecs[1]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), opValid, 1);
      check($sformatf("bp_i_%0d", k), opI, 2048);
      check($sformatf("bp_q_%0d", k), opQ, -2048);
      check($sformatf("bp_ready_%0d", k), opReady, 0);
      check($sformatf("bp_state_%0d", k), int'(opDbgState), int'(ST_IDLE));
    end
    @(posedge clk);
    #1;
    exp_q.push_back(pack_exp(vecs[1]));
    ipReady = 1'b1;
    #1;
    check("bp_release_ready", opReady, 1);
    @(posedge clk);
    #1;
    ipValid = 1'b0;
    check("bp_b_accepted", int'(opDbgState), int'(ST_MUL_II));
    check("bp_consumed", opValid, 0);
    wait_valid(lat);
    check("bp_b_latency", lat, 5);
    @(posedge clk);
    #1;

    // Reset in the middle of a complex sample: no result may appear.
    drive(vecs[2]);
    wait_accept("rst_mid", t);
    ipValid = 1'b0;
    n = 0;
    @(negedge clk);
    while (opDbgState != ST_MUL_IQ && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach_iq", int'(opDbgState), int'(ST_MUL_IQ));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", opValid, 0);
    check("rst_mid_i", opI, 0);
    check("rst_mid_q", opQ, 0);
    check("rst_mid_ovf", opOverflow, 0);
    check("rst_mid_ready", opReady, 0);
    check("rst_mid_state", int'(opDbgState), int'(ST_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_no_pulse", opValid, 0);
    exp_q.push_back(pack_exp(vecs[4]));
    drive(vecs[4]);
    wait_accept("post_rst", t);
    ipValid = 1'b0;
    wait_valid(lat);
    check("post_rst_latency", lat, 3);
    @(posedge clk);
    #1;

    // Back-to-back alternating real/complex stream, ipValid and ipReady high.
    for (int k = 0; k < NS; k++) begin
      exp_q.push_back(model(sv[k]));
      drive(sv[k]);
      wait_accept($sformatf("s%0d", k), t_acc[k]);
    end
    ipValid = 1'b0;
    for (int k = 1; k < NS; k++) begin
      check($sformatf("s%0d_spacing", k), t_acc[k] - t_acc[k-1], sv[k-1].mode ? 6 : 4);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("final_drain", exp_q.size(), 0);
    check("final_idle", int'(opDbgState), int'(ST_IDLE));

    summary();
    $finish;
  end

endmodule
